// File: rtl/tdm_demultiplexer_if.sv
// Serial TDM stream in, per-channel parallel words and framing status out.
// The master side feeds the stream; the slave side is the demultiplexer.
interface tdm_demultiplexer_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 8
);

  logic                         din;
  logic                         din_valid;
  logic                         sync;
  logic [CHANNELS*WIDTH-1:0]    ch_data;
  logic [CHANNELS-1:0]          ch_valid;
  logic                         frame_done;
  logic                         sync_err;
  logic                         locked;

  modport master (
    output din,
    output din_valid,
    output sync,
    input  ch_data,
    input  ch_valid,
    input  frame_done,
    input  sync_err,
    input  locked
  );

  modport slave (
    input  din,
    input  din_valid,
    input  sync,
    output ch_data,
    output ch_valid,
    output frame_done,
    output sync_err,
    output locked
  );

endinterface

// File: rtl/tdm_demultiplexer.sv
// Time-division demultiplexer: locks to a frame marker on a serial stream and
// scatters each WIDTH-bit slot into its channel's output register.
module tdm_demultiplexer #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  tdm_demultiplexer_if.slave   bus
);

  localparam int unsigned BitCntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ChCntW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [0:0] {
    StHunt,
    StRecv
  } state_e;

  state_e                      state_q, state_d;
  logic [WIDTH-2:0]            shift_q, shift_d;
  logic [BitCntW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [ChCntW-1:0]           ch_cnt_q, ch_cnt_d;
  logic [CHANNELS*WIDTH-1:0]   ch_data_q, ch_data_d;
  logic [CHANNELS-1:0]         ch_valid_q, ch_valid_d;
  logic                        frame_done_q, frame_done_d;
  logic                        sync_err_q, sync_err_d;

  logic [WIDTH-1:0]            shift_ext;
  logic                        at_boundary;
  logic                        last_bit;
  logic                        last_ch;

  // Incoming bit appended below the held bits; on the last bit this is the full slot.
  assign shift_ext   = {shift_q, bus.din};
  assign at_boundary = (bit_cnt_q == '0) && (ch_cnt_q == '0);
  assign last_bit    = (bit_cnt_q == BitCntW'(WIDTH - 1));
  assign last_ch     = (ch_cnt_q == ChCntW'(CHANNELS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StHunt;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    ch_data_d    = ch_data_q;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        StHunt: begin
          if (bus.sync) begin
            state_d   = StRecv;
            shift_d   = shift_ext[WIDTH-2:0];
            bit_cnt_d = BitCntW'(1);
            ch_cnt_d  = '0;
          end
        end

        StRecv: begin
          if (bus.sync && !at_boundary) begin
            // Early marker: drop the partial slot and restart the frame on this bit.
            sync_err_d = 1'b1;
            shift_d    = shift_ext[WIDTH-2:0];
            bit_cnt_d  = BitCntW'(1);
            ch_cnt_d   = '0;
          end else if (!bus.sync && at_boundary) begin
            sync_err_d = 1'b1;
            state_d    = StHunt;
          end else begin
            shift_d = shift_ext[WIDTH-2:0];
            if (last_bit) begin
              bit_cnt_d                                  = '0;
              ch_data_d[int'(ch_cnt_q) * WIDTH +: WIDTH] = shift_ext;
              ch_valid_d[ch_cnt_q]                       = 1'b1;
              if (last_ch) begin
                ch_cnt_d     = '0;
                frame_done_d = 1'b1;
              end else begin
                ch_cnt_d = ch_cnt_q + ChCntW'(1);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BitCntW'(1);
            end
          end
        end

        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    bus.ch_data    = ch_data_q;
    bus.ch_valid   = ch_valid_q;
    bus.frame_done = frame_done_q;
    bus.sync_err   = sync_err_q;
    bus.locked     = (state_q == StRecv);
  end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Randomised and directed bench for tdm_demultiplexer against a frame-position model.
module tb_tdm_demultiplexer;

  localparam int C = 2;
  localparam int W = 8;
  localparam int VW = C * W + C + 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tdm_demultiplexer_if #(.CHANNELS(C), .WIDTH(W)) bus ();

  tdm_demultiplexer #(.CHANNELS(C), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the frame plus the slot accumulator.
  logic           exp_locked;
  logic [C*W-1:0] exp_data;
  logic [C-1:0]   exp_valid;
  logic           exp_fd;
  logic           exp_err;
  int             pos;
  int             acc;

  function automatic logic [VW-1:0] obs_vec();
    return {bus.ch_data, bus.ch_valid, bus.frame_done, bus.sync_err, bus.locked};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {exp_data, exp_valid, exp_fd, exp_err, exp_locked};
  endfunction

  task automatic tick(input logic d, input logic v, input logic s, input logic r);
    int k;
    bus.din       = d;
    bus.din_valid = v;
    bus.sync      = s;
    rst           = r;
    @(posedge clk);
    exp_valid = '0;
    exp_fd    = 1'b0;
    exp_err   = 1'b0;
    if (r) begin
      exp_locked = 1'b0;
      exp_data   = '0;
      pos        = 0;
      acc        = 0;
    end else if (v) begin
      if (!exp_locked) begin
        if (s) begin
          exp_locked = 1'b1;
          acc        = int'(d);
          pos        = 1;
        end
      end else if (s && pos != 0) begin
        exp_err = 1'b1;
        acc     = int'(d);
        pos     = 1;
      end else if (!s && pos == 0) begin
        exp_err    = 1'b1;
        exp_locked = 1'b0;
      end else begin
        acc = acc * 2 + int'(d);
        pos++;
        if (pos % W == 0) begin
          k                  = pos / W - 1;
          exp_data[k*W +: W] = acc[W-1:0];
          exp_valid[k]       = 1'b1;
          acc                = 0;
          if (pos == C * W) begin
            exp_fd = 1'b1;
            pos    = 0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== {VW{1'b0}}) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h expected %h", i, obs_vec(), {VW{1'b0}});
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'($urandom_range(1)), 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL hunt_discard beat %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single_frame();
    logic [15:0] fr;
    fr = 16'hA53C;
    for (int i = 0; i < 16; i++) begin
      tick(fr[15-i], 1'b1, i == 0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_frame beat %0d: got %h expected %h", i + 1, obs_vec(), exp_vec());
      end
      checks++;
      if (bus.locked !== 1'b1) begin
        errors++;
        $display("FAIL single_locked beat %0d: got %b expected 1", i + 1, bus.locked);
      end
      if (i == 7) begin
        checks++;
        if (bus.ch_data[7:0] !== 8'hA5 || bus.ch_valid !== 2'b01) begin
          errors++;
          $display("FAIL single_ch0: got %h/%b expected a5/01", bus.ch_data[7:0], bus.ch_valid);
        end
      end
      if (i == 15) begin
        checks++;
        if (bus.ch_data[15:8] !== 8'h3C || bus.ch_valid !== 2'b10 || bus.frame_done !== 1'b1) begin
          errors++;
          $display("FAIL single_ch1: got %h/%b/%b expected 3c/10/1", bus.ch_data[15:8],
                   bus.ch_valid, bus.frame_done);
        end
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.ch_valid !== 2'b00 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_width: got %b/%b expected 00/0", bus.ch_valid, bus.frame_done);
    end
  endtask

  task automatic test_gapped_frame();
    logic [15:0] fr;
    fr = 16'hA53C;
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick(fr[15-i], 1'b1, i == 0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL gapped_beat %0d: got %h expected %h", i + 1, obs_vec(), exp_vec());
      end
      tick(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL gapped_gap %0d: got %h expected %h", i + 1, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.ch_data !== 16'h3CA5) begin
      errors++;
      $display("FAIL gapped_data: got %h expected 3ca5", bus.ch_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] fr;
    int nv, nf, ne;
    fr = 32'h1122_3344;
    nv = 0; nf = 0; ne = 0;
    for (int i = 0; i < 32; i++) begin
      tick(fr[31-i], 1'b1, (i % 16) == 0, 1'b0);
      nv += $countones(bus.ch_valid);
      nf += int'(bus.frame_done);
      ne += int'(bus.sync_err);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b beat %0d: got %h expected %h", i + 1, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (nv != 4 || nf != 2 || ne != 0) begin
      errors++;
      $display("FAIL b2b_counts: got %0d/%0d/%0d expected 4/2/0", nv, nf, ne);
    end
  endtask

  task automatic test_early_sync();
    logic [11:0] pre;
    logic [15:0] fr;
    int ne;
    pre = 12'h96B;
    fr  = 16'h5AC3;
    ne  = 0;
    for (int i = 0; i < 12; i++) begin
      tick(pre[11-i], 1'b1, i == 0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL early_pre beat %0d: got %h expected %h", i + 1, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 16; i++) begin
      tick(fr[15-i], 1'b1, i == 0, 1'b0);
      ne += int'(bus.sync_err);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL early_frame beat %0d: got %h expected %h", i + 1, obs_vec(), exp_vec());
      end
      if (i == 0) begin
        checks++;
        if (bus.ch_data !== 16'h4496 || bus.ch_valid !== 2'b00) begin
          errors++;
          $display("FAIL early_hold: got %h/%b expected 4496/00", bus.ch_data, bus.ch_valid);
        end
      end
    end
    checks++;
    if (ne != 1 || bus.ch_data !== 16'hC35A) begin
      errors++;
      $display("FAIL early_result: got %0d/%h expected 1/c35a", ne, bus.ch_data);
    end
  endtask

  task automatic test_lost_sync();
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.ch_valid !== 2'b00) begin
      errors++;
      $display("FAIL lost_sync: got %b/%b/%b expected 1/0/00", bus.sync_err, bus.locked,
               bus.ch_valid);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec() || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL lost_stays_hunt: got %h expected %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, i == 0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs_vec() !== {VW{1'b0}}) begin
      errors++;
      $display("FAIL mid_slot_reset: got %h expected %h", obs_vec(), {VW{1'b0}});
    end
  endtask

  task automatic test_random();
    logic s;
    for (int i = 0; i < 600; i++) begin
      s = (pos == 0);
      if ($urandom_range(15) == 0) s = ~s;
      tick(1'($urandom_range(1)), $urandom_range(3) != 0, s, $urandom_range(199) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    exp_locked    = 1'b0;
    exp_data      = '0;
    exp_valid     = '0;
    exp_fd        = 1'b0;
    exp_err       = 1'b0;
    pos           = 0;
    acc           = 0;
    test_reset();
    test_single_frame();
    test_gapped_frame();
    test_back_to_back();
    test_early_sync();
    test_lost_sync();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demultiplexer.md
# tdm_demultiplexer

Time-division demultiplexer: the receive end of the team's multiplexer path. It takes one serial, time-multiplexed bit stream, locks to a frame marker, and distributes each WIDTH-bit slot to its channel's parallel output register with a one-cycle valid strobe. It sits downstream of a serialiser or mux chain and feeds per-channel consumers.

## Interface
- CHANNELS, 2: slots per frame; ≥2.
- WIDTH, 8: bits per slot; ≥2.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit, MSB of each slot first.
- din_valid  input  1  din and sync are sampled only when high.
- sync  input  1  frame marker; high with the first bit (MSB of channel 0) of a frame.
- ch_data  output  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]; registered.
- ch_valid  output  CHANNELS  bit k pulses one cycle when ch_data slice k is updated.
- frame_done  output  1  one-cycle pulse when the last channel of a frame completes.
- sync_err  output  1  one-cycle pulse on a framing error.
- locked  output  1  high while in RECV.

## Operation
- States: HUNT, RECV. Internal: shift register (WIDTH-1 bits), bit_cnt (0..WIDTH-1), ch_cnt (0..CHANNELS-1).
- A beat is a cycle with din_valid=1. Cycles with din_valid=0 hold all state; sync is ignored in those cycles.
- HUNT:
  - A beat with sync=0 is discarded.
  - A beat with sync=1 shifts din in, sets bit_cnt=1 and ch_cnt=0, and moves to RECV.
- RECV, beat with sync=0:
  - Shift din in; bit_cnt++.
  - If bit_cnt was WIDTH-1 (last bit of the slot):
    - slice ch_cnt of ch_data ← {shift, din}; ch_valid[ch_cnt] pulses.
    - bit_cnt←0; ch_cnt←ch_cnt+1, wrapping to 0 after CHANNELS-1.
    - frame_done pulses on the wrap.
  - Exception: at a frame boundary (bit_cnt=0, ch_cnt=0), a beat with sync=0 is a lost-sync error. The bit is discarded, sync_err pulses, and the block moves to HUNT.
- RECV, beat with sync=1:
  - At a frame boundary: normal first bit, same as the sync=0 case.
  - Elsewhere (early sync): sync_err pulses, and any partial slot is discarded. Slices already completed in this frame keep their values. The frame restarts with this bit as channel-0 MSB: bit_cnt=1, ch_cnt=0, state stays RECV.
- ch_data slices change only on their own completion and are otherwise held.

## Timing
- Reset (rst high at a clock edge): state=HUNT, ch_data=0, ch_valid=0, frame_done=0, sync_err=0, locked=0, counters and shift register cleared. Reset mid-frame drops the partial frame. Reset takes priority over every other input.
- Latency: ch_data slice and ch_valid bit are valid in the cycle after the edge that samples the slot's last bit. frame_done coincides with ch_valid[CHANNELS-1].
- Every pulse lasts exactly one cycle. There are no back-to-back ch_valid pulses on the same bit closer than WIDTH beats apart.
- locked rises in the cycle after the sync beat that leaves HUNT. It falls in the cycle after a lost-sync beat.
- sync_err and ch_valid are never asserted in the same cycle by the same beat: an error beat never completes a slot.
- There is no backpressure. Consumers must capture data while ch_valid is high or before the next completion of that slice.

## Test plan
All scenarios use CHANNELS=2, WIDTH=8.
- Reset, then idle for 5 cycles → all outputs 0, locked=0. Beats with sync=0 in HUNT → no outputs change.
- Frame 0xA5, 0x3C sent continuously with sync on the first beat:
  - After beat 8: ch_data[7:0]=0xA5 and ch_valid=01 for one cycle.
  - After beat 16: ch_data[15:8]=0x3C, ch_valid=10, frame_done=1.
  - locked=1 from beat 2.
- The same frame with din_valid low on alternate cycles gives an identical data result. Pulses are delayed to match, and state holds across the gaps.
- Two consecutive frames (0x11, 0x22), then (0x33, 0x44), with correct syncs → four ch_valid pulses, two frame_done pulses, sync_err never asserted.
- sync asserted at beat 5 of channel 1 → sync_err pulses once, and ch_data[7:0] keeps its prior value. The following 16 beats (0x5A, 0xC3) complete normally.
- Frame boundary reached with a sync=0 beat → sync_err pulses, locked falls, and the block returns to HUNT. rst asserted mid-slot → all outputs 0 on the next cycle.
